// File: rtl/ld_pad_pkg.sv
// Shared types for the load-side row padding injector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ld_pad_pkg;

  // Layer FSM: four config words, one product cycle, then streaming.
  typedef enum logic [2:0] {
    CFG_W  = 3'd0,
    CFG_H  = 3'd1,
    CFG_OC = 3'd2,
    CFG_B  = 3'd3,
    CALC   = 3'd4,
    RUN    = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Loop words arrive minus-one encoded. Width and height become counts,
  // oc and batch stay as last-index values.
  localparam int DIM_DECODE_ADD  = 1;
  localparam int LAST_DECODE_ADD = 0;

  // Per-request tag carried through the in-order FIFO.
  localparam logic TAG_REAL = 1'b0;
  localparam logic TAG_PAD  = 1'b1;

endpackage

// File: rtl/ld_pad_tag_fifo.sv
// In-order 1-bit tag FIFO recording whether each accepted request is padded.
// Latency: a pushed tag is visible at the head one cycle after the push.
// Backpressure: push ignored when full (even with a same-cycle pop); flush empties.
module ld_pad_tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic full,
  output logic empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_tag = mem[rd_ptr];

  // Tag storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Pointer and occupancy bookkeeping; flush discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ld_pad_inject.sv
// Load path padding: skips DDR reads for rows beyond legal height and injects zero beats.
// Latency: request-to-head 1 cycle via tag FIFO; data merge is combinational.
// Backpressure: in_addr_ready drops on full tag FIFO, DDR req stall or outside RUN.
module ld_pad_inject
  import ld_pad_pkg::*;
#(
  parameter int IMM_WIDTH   = 16,
  parameter int LOOP_ITER_W = 16,
  parameter int ADDR_W      = 42,
  parameter int DATA_W      = 64,
  parameter int TAG_DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_block_padding_v,
  input  logic [IMM_WIDTH-1:0]   diff_rows,
  input  logic                   cfg_loop_iter_ld_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter_ld,
  input  logic                   in_addr_valid,
  output logic                   in_addr_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  output logic                   ddr_req_valid,
  input  logic                   ddr_req_ready,
  output logic [ADDR_W-1:0]      ddr_req_addr,
  input  logic                   ddr_rdata_valid,
  output logic                   ddr_rdata_ready,
  input  logic [DATA_W-1:0]      ddr_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   pad_active,
  output logic                   all_done
);
  localparam int DIM_W = LOOP_ITER_W + 1;
  localparam int PTS_W = 2 * LOOP_ITER_W;
  localparam int CMP_W = (IMM_WIDTH > DIM_W) ? IMM_WIDTH : DIM_W;

  state_t                 state, state_nxt;
  logic [IMM_WIDTH-1:0]   diff_q;
  logic [DIM_W-1:0]       w_q, h_q, legal_h;
  logic [LOOP_ITER_W-1:0] oc_last, b_last, oc_cnt, b_cnt;
  logic [PTS_W-1:0]       full_pts, legal_pts, pt_cnt;
  logic [PTS_W-1:0]       full_c, legal_c;
  logic                   fifo_full, fifo_empty, head_tag;
  logic                   in_run, is_pad, acc, pop;
  logic                   pt_wrap, oc_wrap, last_pt;

  assign ddr_req_addr = in_addr;
  assign pad_active   = (diff_q != '0);
  assign all_done     = (state == DONE) && fifo_empty;
  assign pt_wrap      = (pt_cnt == full_pts - PTS_W'(1));
  assign oc_wrap      = (oc_cnt == oc_last);
  assign last_pt      = pt_wrap && oc_wrap && (b_cnt == b_last);

  // Plane sizes; legal height saturates at zero when padding covers the plane.
  always_comb begin
    legal_h = '0;
    if (CMP_W'(diff_q) < CMP_W'(h_q)) legal_h = DIM_W'(CMP_W'(h_q) - CMP_W'(diff_q));
    full_c  = PTS_W'(w_q) * PTS_W'(h_q);
    legal_c = PTS_W'(w_q) * PTS_W'(legal_h);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= CFG_W;
    else       state <= state_nxt;
  end

  // Next state plus request-side handshake; a new-layer pulse overrides everything.
  always_comb begin
    state_nxt     = state;
    in_run        = (state == RUN) && !cfg_block_padding_v;
    is_pad        = (pt_cnt >= legal_pts);
    in_addr_ready = in_run && !fifo_full && (is_pad || ddr_req_ready);
    ddr_req_valid = in_run && in_addr_valid && !is_pad && !fifo_full;
    acc           = in_addr_valid && in_addr_ready;
    if (cfg_block_padding_v) begin
      state_nxt = CFG_W;
    end else begin
      case (state)
        CFG_W:   if (cfg_loop_iter_ld_v) state_nxt = CFG_H;
        CFG_H:   if (cfg_loop_iter_ld_v) state_nxt = CFG_OC;
        CFG_OC:  if (cfg_loop_iter_ld_v) state_nxt = CFG_B;
        CFG_B:   if (cfg_loop_iter_ld_v) state_nxt = CALC;
        CALC:    state_nxt = RUN;
        RUN:     if (acc && last_pt) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = CFG_W;
      endcase
    end
  end

  // Layer configuration capture and one-shot plane size computation.
  always_ff @(posedge clk) begin
    if (reset) begin
      diff_q    <= '0;
      w_q       <= '0;
      h_q       <= '0;
      oc_last   <= '0;
      b_last    <= '0;
      full_pts  <= '0;
      legal_pts <= '0;
    end else if (cfg_block_padding_v) begin
      diff_q <= diff_rows;
    end else begin
      if (cfg_loop_iter_ld_v) begin
        case (state)
          CFG_W:   w_q     <= DIM_W'(cfg_loop_iter_ld) + DIM_W'(DIM_DECODE_ADD);
          CFG_H:   h_q     <= DIM_W'(cfg_loop_iter_ld) + DIM_W'(DIM_DECODE_ADD);
          CFG_OC:  oc_last <= cfg_loop_iter_ld + LOOP_ITER_W'(LAST_DECODE_ADD);
          CFG_B:   b_last  <= cfg_loop_iter_ld + LOOP_ITER_W'(LAST_DECODE_ADD);
          default: ;
        endcase
      end
      if (state == CALC) begin
        full_pts  <= full_c;
        legal_pts <= legal_c;
      end
    end
  end

  // Point / channel-plane / batch counters advance once per accepted request.
  always_ff @(posedge clk) begin
    if (reset || cfg_block_padding_v) begin
      pt_cnt <= '0;
      oc_cnt <= '0;
      b_cnt  <= '0;
    end else if (acc) begin
      if (pt_wrap) begin
        pt_cnt <= '0;
        if (oc_wrap) begin
          oc_cnt <= '0;
          b_cnt  <= b_cnt + LOOP_ITER_W'(1);
        end else begin
          oc_cnt <= oc_cnt + LOOP_ITER_W'(1);
        end
      end else begin
        pt_cnt <= pt_cnt + PTS_W'(1);
      end
    end
  end

  // Merge: padded head emits zero without touching DDR, real head forwards DDR data.
  always_comb begin
    out_valid       = 1'b0;
    out_data        = '0;
    ddr_rdata_ready = 1'b0;
    if (!fifo_empty) begin
      if (head_tag == TAG_PAD) begin
        out_valid = 1'b1;
      end else begin
        out_valid       = ddr_rdata_valid;
        out_data        = ddr_rdata;
        ddr_rdata_ready = out_ready;
      end
    end
    pop = out_valid && out_ready;
  end

  ld_pad_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (cfg_block_padding_v),
    .push     (acc),
    .push_tag (is_pad ? TAG_PAD : TAG_REAL),
    .pop      (pop),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ld_pad_inject.sv
// Self-checking bench for ld_pad_inject: scoreboard of expected beats plus a DDR latency model.
// Latency: inputs driven on negedge, outputs sampled #1 later, handshakes complete on posedge.
// Backpressure: DDR model with configurable read latency, consumer ready steady or toggling.
module tb_ld_pad_inject;
  localparam int IMM_WIDTH   = 16;
  localparam int LOOP_ITER_W = 16;
  localparam int ADDR_W      = 42;
  localparam int DATA_W      = 64;
  localparam int TAG_DEPTH   = 16;
  localparam logic [ADDR_W-1:0] ADDR_BASE = 42'h100_0000;
  localparam logic [DATA_W-1:0] JUNK      = 64'hDEAD_BEEF_DEAD_BEEF;

  logic                   clk;
  logic                   reset;
  logic                   cfg_block_padding_v;
  logic [IMM_WIDTH-1:0]   diff_rows;
  logic                   cfg_loop_iter_ld_v;
  logic [LOOP_ITER_W-1:0] cfg_loop_iter_ld;
  logic                   in_addr_valid, in_addr_ready;
  logic [ADDR_W-1:0]      in_addr;
  logic                   ddr_req_valid, ddr_req_ready;
  logic [ADDR_W-1:0]      ddr_req_addr;
  logic                   ddr_rdata_valid, ddr_rdata_ready;
  logic [DATA_W-1:0]      ddr_rdata;
  logic                   out_valid, out_ready;
  logic [DATA_W-1:0]      out_data;
  logic                   pad_active, all_done;

  ld_pad_inject #(
    .IMM_WIDTH(IMM_WIDTH), .LOOP_ITER_W(LOOP_ITER_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_block_padding_v(cfg_block_padding_v), .diff_rows(diff_rows),
    .cfg_loop_iter_ld_v(cfg_loop_iter_ld_v), .cfg_loop_iter_ld(cfg_loop_iter_ld),
    .in_addr_valid(in_addr_valid), .in_addr_ready(in_addr_ready), .in_addr(in_addr),
    .ddr_req_valid(ddr_req_valid), .ddr_req_ready(ddr_req_ready), .ddr_req_addr(ddr_req_addr),
    .ddr_rdata_valid(ddr_rdata_valid), .ddr_rdata_ready(ddr_rdata_ready), .ddr_rdata(ddr_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pad_active(pad_active), .all_done(all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model / scoreboard state.
  int plane, legal, n_req, req_idx, beats, n_ddr, lat, cyc, max_occ, diff_cur;
  bit toggle, hold_out;
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] ddr_q[$];
  int                ddr_t[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dat_of(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = 64'hC0DE_0000_0000_0000 | DATA_W'(a);
    return d;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_addr_ready"},   in_addr_ready,   0);
    check_eq({tag, "_ddr_req_valid"},   ddr_req_valid,   0);
    check_eq({tag, "_ddr_rdata_ready"}, ddr_rdata_ready, 0);
    check_eq({tag, "_out_valid"},       out_valid,       0);
    check_eq({tag, "_out_data"},        out_data,        0);
    check_eq({tag, "_pad_active"},      pad_active,      0);
    check_eq({tag, "_all_done"},        all_done,        0);
  endtask

  // One bench cycle: drive at negedge, sample the handshakes that will fire at the next posedge.
  task automatic cycle();
    bit pad;
    @(negedge clk);
    cyc++;
    cfg_block_padding_v = 1'b0;
    cfg_loop_iter_ld_v  = 1'b0;
    in_addr_valid = (req_idx < n_req);
    in_addr       = ADDR_BASE + ADDR_W'(req_idx);
    ddr_req_ready = 1'b1;
    if (ddr_q.size() > 0 && ddr_t[0] <= cyc) begin
      ddr_rdata_valid = 1'b1;
      ddr_rdata       = dat_of(ddr_q[0]);
    end else begin
      ddr_rdata_valid = 1'b0;
      ddr_rdata       = JUNK;
    end
    out_ready = hold_out ? 1'b0 : (toggle ? cyc[0] : 1'b1);
    #1;
    if (exp_q.size() >= TAG_DEPTH && in_addr_valid) check_eq("full_block", in_addr_ready, 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_beat", 1, 0);
      end else begin
        check_eq("done_while_busy", all_done, 0);
        check_eq("out_data", out_data, exp_q.pop_front());
      end
      beats++;
    end
    if (ddr_rdata_valid && ddr_rdata_ready) begin
      void'(ddr_q.pop_front());
      void'(ddr_t.pop_front());
    end
    if (in_addr_valid && in_addr_ready) begin
      pad = ((req_idx % plane) >= legal);
      check_eq("ddr_req_valid", ddr_req_valid, !pad);
      if (!pad) check_eq("ddr_req_addr", ddr_req_addr, in_addr);
      exp_q.push_back(pad ? '0 : dat_of(in_addr));
      req_idx++;
    end
    if (ddr_req_valid && ddr_req_ready) begin
      ddr_q.push_back(ddr_req_addr);
      ddr_t.push_back(cyc + lat);
      n_ddr++;
    end
    if (exp_q.size() > max_occ) max_occ = exp_q.size();
  endtask

  // Optional new-layer pulse, then the four minus-one loop words and the CALC cycle.
  task automatic configure(input bit pulse, input int d, input int w, input int h,
                           input int oc, input int b);
    int words[4];
    words = '{w - 1, h - 1, oc - 1, b - 1};
    if (pulse) begin
      @(negedge clk);
      cfg_block_padding_v = 1'b1;
      diff_rows           = IMM_WIDTH'(d);
      in_addr_valid       = 1'b0;
      ddr_rdata_valid     = 1'b0;
      out_ready           = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_block_padding_v = 1'b0;
      cfg_loop_iter_ld_v  = (i < 4);
      cfg_loop_iter_ld    = (i < 4) ? LOOP_ITER_W'(words[i]) : '0;
      in_addr_valid       = 1'b1;
      in_addr             = ADDR_BASE;
      #1;
      check_eq("cfg_in_ready", in_addr_ready, 0);
      check_eq("cfg_ddr_req",  ddr_req_valid, 0);
    end
    plane    = w * h;
    legal    = (d >= h) ? 0 : w * (h - d);
    n_req    = plane * oc * b;
    diff_cur = d;
    req_idx  = 0;
    beats    = 0;
    n_ddr    = 0;
    max_occ  = 0;
    hold_out = 1'b0;
  endtask

  task automatic run_layer(input string tag, input int lat_i, input bit tog);
    int budget;
    lat    = lat_i;
    toggle = tog;
    budget = 0;
    while ((req_idx < n_req || exp_q.size() > 0) && budget < 3000) begin
      cycle();
      budget++;
    end
    if (budget >= 3000) check_eq({tag, "_timeout"}, 1, 0);
    check_eq({tag, "_beats"}, beats, n_req);
    check_eq({tag, "_ddr_reqs"}, n_ddr, (n_req / plane) * legal);
    check_eq({tag, "_ddr_drained"}, ddr_q.size(), 0);
    @(negedge clk);
    in_addr_valid   = 1'b1;
    ddr_rdata_valid = 1'b0;
    #1;
    check_eq({tag, "_all_done"},   all_done,      1);
    check_eq({tag, "_pad_active"}, pad_active,    diff_cur != 0);
    check_eq({tag, "_done_ready"}, in_addr_ready, 0);
    check_eq({tag, "_done_out"},   out_valid,     0);
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    cfg_block_padding_v = 1'b0; diff_rows = '0;
    cfg_loop_iter_ld_v = 1'b0;  cfg_loop_iter_ld = '0;
    in_addr_valid = 1'b1;  in_addr = ADDR_BASE;
    ddr_req_ready = 1'b1;  ddr_rdata_valid = 1'b1; ddr_rdata = JUNK;
    out_ready = 1'b1;
    cyc = 0; lat = 1; toggle = 1'b0; hold_out = 1'b0;
    plane = 1; legal = 0; n_req = 0; req_idx = 0; beats = 0; n_ddr = 0; max_occ = 0; diff_cur = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // 4x4 planes, 2 planes, bottom row padded.
    configure(1'b1, 1, 4, 4, 2, 1);
    run_layer("pad1", 1, 1'b0);

    // No padding: pure pass-through.
    configure(1'b1, 0, 4, 4, 2, 1);
    run_layer("pad0", 1, 1'b0);

    // Padding exceeds height: every beat injected, no DDR traffic.
    configure(1'b1, 5, 4, 4, 2, 1);
    run_layer("padall", 1, 1'b0);

    // Mid-run restart with 5 outstanding pad tags and a stalled consumer.
    configure(1'b1, 5, 4, 4, 2, 1);
    n_req = 5; hold_out = 1'b1; lat = 200; toggle = 1'b0;
    budget = 0;
    while (req_idx < n_req && budget < 100) begin
      cycle();
      budget++;
    end
    check_eq("flush_outstanding", exp_q.size(), 5);
    check_eq("flush_pre_out_valid", out_valid, 1);
    @(negedge clk);
    cfg_block_padding_v = 1'b1;
    diff_rows           = '0;
    in_addr_valid       = 1'b1;
    out_ready           = 1'b0;
    ddr_rdata_valid     = 1'b0;
    #1;
    check_eq("flush_cycle_ready", in_addr_ready, 0);
    exp_q.delete(); ddr_q.delete(); ddr_t.delete();
    @(negedge clk);
    cfg_block_padding_v = 1'b0;
    out_ready           = 1'b1;
    #1;
    check_eq("flush_out_valid",   out_valid,       0);
    check_eq("flush_in_ready",    in_addr_ready,   0);
    check_eq("flush_rdata_ready", ddr_rdata_ready, 0);
    check_eq("flush_all_done",    all_done,        0);
    check_eq("flush_pad_active",  pad_active,      0);
    configure(1'b0, 0, 2, 2, 1, 1);
    run_layer("after_flush", 2, 1'b0);

    // Long DDR latency with a toggling consumer: tag FIFO fills, order must hold.
    configure(1'b1, 1, 4, 4, 2, 1);
    run_layer("slow", 20, 1'b1);
    check_eq("slow_max_outstanding", max_occ, TAG_DEPTH);

    // Reset while sitting in DONE.
    check_eq("pre_reset_done", all_done, 1);
    check_eq("pre_reset_pad",  pad_active, 1);
    @(negedge clk);
    reset           = 1'b1;
    in_addr_valid   = 1'b1;
    ddr_rdata_valid = 1'b1;
    ddr_rdata       = JUNK;
    out_ready       = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("done_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
